// File: rtl/ccd_pkg.sv
// Shared types and default timing for the linear CCD sequencer.
// States, default drive timing and width helpers.
package ccd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SH,
    S_TAIL,
    S_READ,
    S_GAP
  } state_e;

  localparam int DEF_CLK_DIV = 25;
  localparam int DEF_PIXELS  = 3694;
  localparam int DEF_T_LEAD  = 1;
  localparam int DEF_SH_W    = 2;
  localparam int DEF_T_TAIL  = 2;

  // Bits needed to hold the value v itself (never less than one).
  function automatic int bits_for(input longint v);
    if (v < 2) return 1;
    return $clog2(v + 1);
  endfunction

  // Bits for a 0..n-1 pixel index.
  function automatic int idx_bits(input int n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ccd_mclk_div.sv
// fM divider: free-running CCD_M with one-cycle strobes
// flagging the cycle before each rising/falling edge.
module ccd_mclk_div
  import ccd_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_m,
  output logic o_m_rise,
  output logic o_m_fall
);

  localparam int DW = bits_for(CLK_DIV - 1);

  logic [DW-1:0] r_cnt;
  logic          r_m;
  logic          w_tc;

  assign w_tc = (r_cnt == DW'(CLK_DIV - 1));

  // Count to the terminal value, then toggle CCD_M.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_m   <= 1'b0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_m   <= ~r_m;
    end else begin
      r_cnt <= r_cnt + DW'(1);
    end
  end

  assign o_m      = r_m;
  assign o_m_rise = w_tc & ~r_m;
  assign o_m_fall = w_tc & r_m;

endmodule

// File: rtl/ccd_linear_timing.sv
// Linear CCD timing generator: CCD_M / SH / ICG drive plus pixel strobes.
// Optional electronic shutter when CCD_SHUTTER_EN is defined.
module ccd_linear_timing
  import ccd_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int PIXELS  = DEF_PIXELS,
  parameter int T_LEAD  = DEF_T_LEAD,
  parameter int SH_W    = DEF_SH_W,
  parameter int T_TAIL  = DEF_T_TAIL,
  parameter int INT_W   = 20
) (
  input  logic                          Master_clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [INT_W-1:0]              int_time,
  output logic                          CCD_M,
  output logic                          CCD_SH,
  output logic                          CCD_ICG,
  output logic                          pix_valid,
  output logic [idx_bits(PIXELS)-1:0]   pix_idx,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int IDX_W = idx_bits(PIXELS);
  localparam int CW = max2(
    max2(bits_for(PIXELS), INT_W),
    max2(bits_for(T_LEAD),
      max2(bits_for(SH_W), bits_for(T_TAIL))));

  state_e           r_state;
  state_e           w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic [CW-1:0]    w_dur;
  logic [CW-1:0]    r_gap;
  logic [CW-1:0]    w_gap_in;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nx;
  logic             r_pend;
  logic             w_pend_nx;
  logic             r_icg;
  logic             r_sh;
  logic             w_mr;
  logic             w_mf;
  logic             w_last;
  logic             w_load;
  logic             w_done;
  logic             w_icg_lo_nx;
  logic             w_shut;

  ccd_mclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .i_clk    (Master_clk),
    .i_rst_n  (rst),
    .o_m      (CCD_M),
    .o_m_rise (w_mr),
    .o_m_fall (w_mf)
  );

  assign w_gap_in = (int_time == '0) ? CW'(1)
                                     : CW'(int_time);

  // Length of the current state in fM periods.
  always_comb begin
    w_dur = CW'(1);
    unique case (r_state)
      S_LEAD:  w_dur = CW'(T_LEAD);
      S_SH:    w_dur = CW'(SH_W);
      S_TAIL:  w_dur = CW'(T_TAIL);
      S_READ:  w_dur = CW'(PIXELS);
      S_GAP:   w_dur = r_gap;
      default: w_dur = CW'(1);
    endcase
  end

  assign w_last = (r_cnt == w_dur - CW'(1));

  // Next state: moves only on m_rise; start held pending in IDLE.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pend_nx  = r_pend;
    w_load     = 1'b0;
    w_done     = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_mr && (r_pend || start || continuous)) begin
        w_state_nx = S_LEAD;
        w_pend_nx  = 1'b0;
        w_load     = 1'b1;
      end else if (start) begin
        w_pend_nx = 1'b1;
      end
    end else if (w_mr) begin
      if (w_last) begin
        w_cnt_nx = '0;
        unique case (r_state)
          S_LEAD: w_state_nx = S_SH;
          S_SH:   w_state_nx = S_TAIL;
          S_TAIL: w_state_nx = S_READ;
          S_READ: w_state_nx = S_GAP;
          S_GAP: begin
            w_done = 1'b1;
            if (continuous) begin
              w_state_nx = S_LEAD;
              w_load     = 1'b1;
            end else begin
              w_state_nx = S_IDLE;
            end
          end
          default: w_state_nx = S_IDLE;
        endcase
      end else begin
        w_cnt_nx = r_cnt + CW'(1);
      end
    end
  end

  assign w_icg_lo_nx = (w_state_nx == S_LEAD) ||
                       (w_state_nx == S_SH)   ||
                       (w_state_nx == S_TAIL);

  // Pixel index advances after each strobe, holds on the last pixel.
  always_comb begin
    w_idx_nx = r_idx;
    if (w_state_nx != S_READ) begin
      w_idx_nx = '0;
    end else if (r_state == S_READ && w_mf &&
                 r_idx != IDX_W'(PIXELS - 1)) begin
      w_idx_nx = r_idx + IDX_W'(1);
    end
  end

`ifdef CCD_SHUTTER_EN
  localparam int SW_W = bits_for(SH_W);

  logic [CW-1:0]   r_ph;
  logic [CW-1:0]   w_ph_nx;
  logic [SW_W-1:0] r_shl;
  logic [SW_W-1:0] w_shl_nx;
  logic            w_ro;
  logic            w_ro_nx;

  assign w_ro    = (r_state == S_READ) ||
                   (r_state == S_GAP);
  assign w_ro_nx = (w_state_nx == S_READ) ||
                   (w_state_nx == S_GAP);

  // Shutter phase counts fM periods since ICG rise, mod int_time.
  always_comb begin
    w_ph_nx  = r_ph;
    w_shl_nx = r_shl;
    if (!w_ro_nx) begin
      w_ph_nx  = '0;
      w_shl_nx = '0;
    end else if (w_mr && w_ro) begin
      if (r_ph == r_gap - CW'(1)) w_ph_nx = '0;
      else                        w_ph_nx = r_ph + CW'(1);
      if (w_ph_nx == '0)          w_shl_nx = SW_W'(SH_W);
      else if (r_shl != '0)       w_shl_nx = r_shl - SW_W'(1);
    end
  end

  // Shutter phase and remaining pulse length registers.
  always_ff @(posedge Master_clk or negedge rst) begin
    if (!rst) begin
      r_ph  <= '0;
      r_shl <= '0;
    end else begin
      r_ph  <= w_ph_nx;
      r_shl <= w_shl_nx;
    end
  end

  assign w_shut = (w_shl_nx != '0);
`else
  assign w_shut = 1'b0;
`endif

  // State, counters and registered sensor drive lines.
  always_ff @(posedge Master_clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_gap   <= CW'(1);
      r_icg   <= 1'b1;
      r_sh    <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
      if (w_load) r_gap <= w_gap_in;
      r_icg   <= ~w_icg_lo_nx;
      r_sh    <= (w_state_nx == S_SH) | w_shut;
      r_idx   <= w_idx_nx;
    end
  end

  assign CCD_ICG    = r_icg;
  assign CCD_SH     = r_sh;
  assign pix_idx    = r_idx;
  assign pix_valid  = (r_state == S_READ) & w_mf;
  assign frame_done = w_done;
  assign busy       = (r_state != S_IDLE);

endmodule
